// File: rtl/rr_arbiter_ctrl.sv
// Round-robin arbiter with hold-time preemption.
// Registered one-hot grant, binary id and change pulse.
module rr_arbiter_ctrl #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         req,
  output logic [WIDTH-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(WIDTH)-1:0] grant_id,
  output logic                     grant_change
);

  localparam int IDW = $clog2(WIDTH);
  localparam int CW  = $clog2(MAX_HOLD) + 1;
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_LAST);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_n;
  logic [WIDTH-1:0] base, base_n;
  logic [WIDTH-1:0] grant_n;
  logic [CW-1:0]    hold_cnt, cnt_n;
  logic             change_n;
  logic [WIDTH-1:0] rot_grant;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] sel_base;
  logic [WIDTH-1:0] pick;
  logic             release_now;

  // First set bit of r, scanning upward from the one-hot base b with wrap.
  function automatic logic [WIDTH-1:0] select(
    input logic [WIDTH-1:0] r,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] res;
    logic             found;
    int               bi;
    int               idx;
    res   = '0;
    found = 1'b0;
    bi    = 0;
    for (int i = 0; i < WIDTH; i++)
      if (b[i]) bi = i;
    for (int k = 0; k < WIDTH; k++) begin
      idx = (bi + k) % WIDTH;
      if (!found && r[idx]) begin
        res[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [IDW-1:0] to_idx(input logic [WIDTH-1:0] oh);
    logic [IDW-1:0] id;
    id = '0;
    for (int i = 0; i < WIDTH; i++)
      if (oh[i]) id = IDW'(i);
    return id;
  endfunction

  assign rot_grant = {grant[WIDTH-2:0], grant[WIDTH-1]};
  assign cand      = (state == IDLE) ? req : (req & ~grant);
  assign sel_base  = (state == IDLE) ? base : rot_grant;
  assign pick      = select(cand, sel_base);

  // Holder dropped, or held its full quota while someone else waits.
  assign release_now = ((req & grant) == '0) ||
                       ((MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) &&
                        ((req & ~grant) != '0));

  // Next-state, next grant, base rotation and hold counting.
  always_comb begin
    state_n  = state;
    grant_n  = grant;
    base_n   = base;
    cnt_n    = hold_cnt;
    change_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (req != '0) begin
          grant_n  = pick;
          state_n  = BUSY;
          cnt_n    = '0;
          change_n = 1'b1;
        end
      end
      BUSY: begin
        if (release_now) begin
          base_n = rot_grant;
          cnt_n  = '0;
          if (cand != '0) begin
            grant_n  = pick;
            change_n = 1'b1;
          end else begin
            grant_n = '0;
            state_n = IDLE;
          end
        end else if (hold_cnt != HOLD_MAX) begin
          cnt_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  // State and registered outputs; reset parks base at index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      base         <= WIDTH'(1);
      grant        <= '0;
      hold_cnt     <= '0;
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      grant_change <= 1'b0;
    end else begin
      state        <= state_n;
      base         <= base_n;
      grant        <= grant_n;
      hold_cnt     <= cnt_n;
      grant_valid  <= |grant_n;
      grant_id     <= to_idx(grant_n);
      grant_change <= change_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Directed bench for rr_arbiter_ctrl at WIDTH=4, MAX_HOLD=4.
// Inputs change #1 after the rising edge; outputs are checked there.
module tb_rr_arbiter_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       grant_change;

  int checks;
  int errors;

  rr_arbiter_ctrl #(.WIDTH(4), .MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .grant_change(grant_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({grant, grant_valid, grant_id, grant_change} !== 8'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got g=%b v=%b id=%0d c=%b want 0",
                 i, grant, grant_valid, grant_id, grant_change);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (grant !== 4'b0001 || grant_change !== 1'b1 || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_first got g=%b c=%b v=%b want g=0001 c=1 v=1",
               grant, grant_change, grant_valid);
    end
  endtask

  task automatic test_first_grant();
    do_reset();
    req = 4'b1010;
    step();
    checks++;
    if (grant !== 4'b0010 || grant_id !== 2'd1 || grant_change !== 1'b1) begin
      errors++;
      $display("FAIL first_grant got g=%b id=%0d c=%b want g=0010 id=1 c=1",
               grant, grant_id, grant_change);
    end
    step();
    checks++;
    if (grant !== 4'b0010 || grant_change !== 1'b0) begin
      errors++;
      $display("FAIL first_grant_hold got g=%b c=%b want g=0010 c=0",
               grant, grant_change);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] eg;
    logic       ec;
    do_reset();
    req = 4'b1111;
    for (int s = 0; s <= 16; s++) begin
      step();
      eg = 4'b0001 << ((s / 4) % 4);
      ec = (s % 4 == 0);
      checks++;
      if (grant !== eg || grant_change !== ec || grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL rotation s=%0d got g=%b c=%b v=%b want g=%b c=%b v=1",
                 s, grant, grant_change, grant_valid, eg, ec);
      end
    end
  endtask

  task automatic test_lone_holder();
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (grant !== 4'b0100 || grant_id !== 2'd2 ||
          grant_change !== (i == 0)) begin
        errors++;
        $display("FAIL lone_holder i=%0d got g=%b id=%0d c=%b want g=0100 id=2 c=%b",
                 i, grant, grant_id, grant_change, (i == 0));
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b1000;
    step();
    checks++;
    if (grant !== 4'b1000 || grant_id !== 2'd3) begin
      errors++;
      $display("FAIL wrap_setup got g=%b id=%0d want g=1000 id=3",
               grant, grant_id);
    end
    req = 4'b0001;
    step();
    checks++;
    if (grant !== 4'b0001 || grant_valid !== 1'b1 ||
        grant_change !== 1'b1 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL wrap_handover got g=%b v=%b c=%b id=%0d want g=0001 v=1 c=1 id=0",
               grant, grant_valid, grant_change, grant_id);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b0011;
    step();
    checks++;
    if (grant !== 4'b0001 || grant_change !== 1'b0) begin
      errors++;
      $display("FAIL nonholder_rise got g=%b c=%b want g=0001 c=0",
               grant, grant_change);
    end
    req = 4'b0001;
    step();
    checks++;
    if (grant !== 4'b0001 || grant_change !== 1'b0) begin
      errors++;
      $display("FAIL nonholder_fall got g=%b c=%b want g=0001 c=0",
               grant, grant_change);
    end
    req = 4'b0100;
    step();
    checks++;
    if (grant !== 4'b0100 || grant_change !== 1'b1 || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL direct_handover got g=%b c=%b v=%b want g=0100 c=1 v=1",
               grant, grant_change, grant_valid);
    end
    req = 4'b0000;
    step();
    checks++;
    if ({grant, grant_valid, grant_id, grant_change} !== 8'b0) begin
      errors++;
      $display("FAIL go_idle got g=%b v=%b id=%0d c=%b want 0",
               grant, grant_valid, grant_id, grant_change);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 9; i++) step();
    checks++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL mid_setup got g=%b want 0100", grant);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({grant, grant_valid, grant_id, grant_change} !== 8'b0) begin
      errors++;
      $display("FAIL mid_reset got g=%b v=%b id=%0d c=%b want 0",
               grant, grant_valid, grant_id, grant_change);
    end
    rst = 1'b0;
    step();
    checks++;
    if (grant !== 4'b0001 || grant_change !== 1'b1) begin
      errors++;
      $display("FAIL mid_after got g=%b c=%b want g=0001 c=1",
               grant, grant_change);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    req    = 4'b0000;
    test_reset();
    test_first_grant();
    test_rotation();
    test_lone_holder();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
